mem2io_bridge: RTL and testbench

//  Sits downstream of the SLC-3 control unit and datapath, between the CPU memory port
//  (MAR address, MDR data, active-low Mem_CE/OE/WE/UB/LB) and the off-chip SRAM plus board I/O.

---
 rtl/mem2io_if.sv | 25 ++
 rtl/mem2io_bridge.sv | 85 ++++++++
 tb/tb_mem2io_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem2io_if.sv
// CPU-side memory port of the SLC-3 bridge.
// Control strobes are active-low; Data_to_CPU returns to the CPU.
`timescale 1ns/1ps
interface mem2io_if;
  logic [15:0] ADDR;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;

  modport master (
    output ADDR, Mem_CE, Mem_OE, Mem_WE,
    output Mem_UB, Mem_LB, Data_from_CPU,
    input  Data_to_CPU
  );

  modport slave (
    input  ADDR, Mem_CE, Mem_OE, Mem_WE,
    input  Mem_UB, Mem_LB, Data_from_CPU,
    output Data_to_CPU
  );
endinterface

// File: rtl/mem2io_bridge.sv
// SLC-3 memory port to async SRAM and board I/O.
// One decoded word: switch reads and hex-display writes.
`timescale 1ns/1ps
module mem2io_bridge #(
  parameter logic [15:0] IO_ADDR     = 16'hFFFF,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] HEX_RESET   = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  mem2io_if.slave     cpu,
  input  logic [15:0] Switches,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [15:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic [3:0]  HEX0,
  output logic [3:0]  HEX1,
  output logic [3:0]  HEX2,
  output logic [3:0]  HEX3
);

  logic        w_io_hit;
  logic        w_rd;
  logic        w_hex_wr;
  logic [15:0] w_rd_data;
  logic [15:0] r_hex;
  logic [15:0] r_dout;
  logic [15:0] r_sync [SYNC_STAGES];

  assign w_io_hit = (cpu.ADDR == IO_ADDR) & ~cpu.Mem_CE;

  // A simultaneous OE/WE request is a write, so OE is masked by ~WE.
  assign SRAM_CE_N = cpu.Mem_CE | w_io_hit;
  assign SRAM_WE_N = cpu.Mem_WE | cpu.Mem_CE | w_io_hit;
  assign SRAM_OE_N = cpu.Mem_OE | cpu.Mem_CE | w_io_hit
                   | ~cpu.Mem_WE;
  assign SRAM_UB_N = cpu.Mem_UB;
  assign SRAM_LB_N = cpu.Mem_LB;
  assign SRAM_ADDR = cpu.ADDR;

  assign SRAM_DQ = SRAM_WE_N ? 16'hzzzz : cpu.Data_from_CPU;

  assign w_rd     = ~cpu.Mem_CE & ~cpu.Mem_OE & cpu.Mem_WE;
  assign w_hex_wr = ~cpu.Mem_WE & w_io_hit;
  assign w_rd_data = w_io_hit ? r_sync[SYNC_STAGES-1] : SRAM_DQ;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= Switches;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dout <= '0;
    end else if (w_rd) begin
      r_dout <= w_rd_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hex <= HEX_RESET;
    end else if (w_hex_wr) begin
      r_hex <= cpu.Data_from_CPU;
    end
  end

  assign cpu.Data_to_CPU = r_dout;

  assign HEX0 = r_hex[3:0];
  assign HEX1 = r_hex[7:4];
  assign HEX2 = r_hex[11:8];
  assign HEX3 = r_hex[15:12];

endmodule

// File: tb/tb_mem2io_bridge.sv
// Bench for mem2io_bridge: strobe table, directed
// access sequences, then random traffic vs a word-level model.
`timescale 1ns/1ps
module tb_mem2io_bridge;

  localparam int SYNC = 2;

  logic        Clk;
  logic        Reset;
  logic [15:0] Switches;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic        SRAM_UB_N, SRAM_LB_N;
  logic [15:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic [3:0]  HEX0, HEX1, HEX2, HEX3;

  mem2io_if bus ();

  mem2io_bridge #(
    .IO_ADDR     (16'hFFFF),
    .SYNC_STAGES (SYNC),
    .HEX_RESET   (16'h0000)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu       (bus),
    .Switches  (Switches),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Off-chip SRAM seen by the DUT
  logic [15:0] env_mem [int];
  logic [15:0] env_rd;
  logic        w_env_drv;

  function automatic logic [15:0] env_read(input logic [15:0] a);
    if (env_mem.exists(int'(a))) return env_mem[int'(a)];
    return dflt(a);
  endfunction

  assign w_env_drv = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = w_env_drv ? env_rd : 16'hzzzz;

  initial begin
    env_rd = 16'h0;
    forever begin
      #1;
      env_rd = env_read(SRAM_ADDR);
    end
  end

  initial begin
    forever begin
      @(posedge Clk);
      if (!SRAM_WE_N && !SRAM_CE_N) begin
        logic [15:0] w;
        w = env_read(SRAM_ADDR);
        if (!SRAM_UB_N) w[15:8] = SRAM_DQ[15:8];
        if (!SRAM_LB_N) w[7:0]  = SRAM_DQ[7:0];
        env_mem[int'(SRAM_ADDR)] = w;
      end
    end
  end

  // Reference model: memory contents, hex word, read word,
  // and a history of switch samples (oldest first).
  logic [15:0] ref_mem [int];
  logic [15:0] m_hex;
  logic [15:0] m_dout;
  logic [15:0] m_swq [$];

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return dflt(a);
  endfunction

  task automatic model_reset();
    m_hex  = 16'h0000;
    m_dout = 16'h0000;
    m_swq.delete();
    for (int i = 0; i < SYNC; i++) m_swq.push_back(16'h0);
  endtask

  task automatic model_edge();
    logic [15:0] sw_old, w;
    logic io, ce, oe, we;
    ce = bus.Mem_CE; oe = bus.Mem_OE; we = bus.Mem_WE;
    sw_old = m_swq.pop_front();
    m_swq.push_back(Switches);
    io = (bus.ADDR == 16'hFFFF) && !ce;
    if (!ce && !oe && we)
      m_dout = io ? sw_old : ref_read(bus.ADDR);
    if (!ce && !we) begin
      if (io) begin
        m_hex = bus.Data_from_CPU;
      end else begin
        w = ref_read(bus.ADDR);
        if (!bus.Mem_UB) w[15:8] = bus.Data_from_CPU[15:8];
        if (!bus.Mem_LB) w[7:0]  = bus.Data_from_CPU[7:0];
        ref_mem[int'(bus.ADDR)] = w;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) model_reset();
      else model_edge();
    end
  end

  task automatic drive(input logic [15:0] a,
                       input logic ce, input logic oe,
                       input logic we, input logic [15:0] d);
    bus.ADDR = a; bus.Mem_CE = ce; bus.Mem_OE = oe;
    bus.Mem_WE = we; bus.Data_from_CPU = d;
  endtask

  task automatic idle();
    drive(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000);
    bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
  endtask

  function automatic logic [15:0] hexw();
    return {HEX3, HEX2, HEX1, HEX0};
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic ce, oe, we, ub, lb;
    logic xce, xoe, xwe;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [15:0] hold;
    tbl[0] = '{16'h0040, 1'b0,1'b0,1'b1, 1'b0,1'b0, 1'b0,1'b0,1'b1};
    tbl[1] = '{16'h0040, 1'b0,1'b1,1'b0, 1'b1,1'b0, 1'b0,1'b1,1'b0};
    tbl[2] = '{16'h0040, 1'b0,1'b0,1'b0, 1'b0,1'b1, 1'b0,1'b1,1'b0};
    tbl[3] = '{16'h0040, 1'b1,1'b0,1'b1, 1'b1,1'b1, 1'b1,1'b1,1'b1};
    tbl[4] = '{16'hFFFF, 1'b0,1'b0,1'b1, 1'b0,1'b0, 1'b1,1'b1,1'b1};
    tbl[5] = '{16'hFFFF, 1'b0,1'b1,1'b0, 1'b0,1'b0, 1'b1,1'b1,1'b1};
    tbl[6] = '{16'hFFFF, 1'b1,1'b1,1'b0, 1'b1,1'b0, 1'b1,1'b1,1'b1};
    tbl[7] = '{16'hFFFE, 1'b0,1'b0,1'b1, 1'b0,1'b1, 1'b0,1'b0,1'b1};
    tbl[8] = '{16'h1000, 1'b0,1'b1,1'b1, 1'b0,1'b0, 1'b0,1'b1,1'b1};

    Reset = 1'b1;
    Switches = 16'h0000;
    idle();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst hex", hexw(), 16'h0000);
    chk("rst dout", bus.Data_to_CPU, 16'h0000);
    chk("rst we_n", 16'(SRAM_WE_N), 16'h1);

    // Combinational strobe gating
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      drive(tbl[i].addr, tbl[i].ce, tbl[i].oe, tbl[i].we, 16'h0000);
      bus.Mem_UB = tbl[i].ub; bus.Mem_LB = tbl[i].lb;
      #1;
      chk($sformatf("tbl%0d ce_n", i), 16'(SRAM_CE_N), 16'(tbl[i].xce));
      chk($sformatf("tbl%0d oe_n", i), 16'(SRAM_OE_N), 16'(tbl[i].xoe));
      chk($sformatf("tbl%0d we_n", i), 16'(SRAM_WE_N), 16'(tbl[i].xwe));
      chk($sformatf("tbl%0d ub_n", i), 16'(SRAM_UB_N), 16'(tbl[i].ub));
      chk($sformatf("tbl%0d lb_n", i), 16'(SRAM_LB_N), 16'(tbl[i].lb));
      chk($sformatf("tbl%0d addr", i), SRAM_ADDR, tbl[i].addr);
    end
    @(negedge Clk); idle();

    // SRAM read, two OE cycles
    env_mem[int'(16'h0040)] = 16'hBEEF;
    ref_mem[int'(16'h0040)] = 16'hBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      drive(16'h0040, 1'b0, 1'b0, 1'b1, 16'h0000);
      #1;
      chk("srd oe_n", 16'(SRAM_OE_N), 16'h0);
      chk("srd we_n", 16'(SRAM_WE_N), 16'h1);
      @(posedge Clk); #1;
      chk("srd dout", bus.Data_to_CPU, 16'hBEEF);
    end
    @(negedge Clk); idle();

    // I/O switch read
    Switches = 16'hA5C3;
    repeat (3) @(negedge Clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      drive(16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000);
      #1;
      chk("iord ce_n", 16'(SRAM_CE_N), 16'h1);
      chk("iord oe_n", 16'(SRAM_OE_N), 16'h1);
      @(posedge Clk); #1;
    end
    chk("iord dout", bus.Data_to_CPU, 16'hA5C3);
    @(negedge Clk); idle();

    // I/O hex write
    @(negedge Clk);
    drive(16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h3F2E);
    #1;
    chk("iowr we_n", 16'(SRAM_WE_N), 16'h1);
    @(posedge Clk); #1;
    chk("iowr hex3", 16'(HEX3), 16'h3);
    chk("iowr hex2", 16'(HEX2), 16'hF);
    chk("iowr hex1", 16'(HEX1), 16'h2);
    chk("iowr hex0", 16'(HEX0), 16'hE);
    @(posedge Clk); #1;
    chk("iowr hex2nd", hexw(), 16'h3F2E);
    @(negedge Clk); idle();

    // SRAM write, upper byte masked
    @(negedge Clk);
    drive(16'h1000, 1'b0, 1'b1, 1'b0, 16'h00FF);
    bus.Mem_UB = 1'b1; bus.Mem_LB = 1'b0;
    #1;
    chk("swr we_n", 16'(SRAM_WE_N), 16'h0);
    chk("swr dq", SRAM_DQ, 16'h00FF);
    chk("swr ub_n", 16'(SRAM_UB_N), 16'h1);
    @(posedge Clk); #1;
    chk("swr hex", hexw(), 16'h3F2E);
    @(negedge Clk); idle();
    #1;
    chk("swr release", 16'(SRAM_WE_N), 16'h1);

    // OE and WE both low: write, no capture
    hold = bus.Data_to_CPU;
    @(negedge Clk);
    drive(16'h0040, 1'b0, 1'b0, 1'b0, 16'h1357);
    #1;
    chk("both oe_n", 16'(SRAM_OE_N), 16'h1);
    chk("both we_n", 16'(SRAM_WE_N), 16'h0);
    @(posedge Clk); #1;
    chk("both dout", bus.Data_to_CPU, hold);

    // Switch change reaches a read only after SYNC clocks
    @(negedge Clk);
    drive(16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000);
    @(posedge Clk); #1;
    chk("sync pre", bus.Data_to_CPU, 16'hA5C3);
    @(negedge Clk);
    Switches = 16'h5A3C;
    @(posedge Clk); #1;
    chk("sync e1", bus.Data_to_CPU, 16'hA5C3);
    @(posedge Clk); #1;
    chk("sync e2", bus.Data_to_CPU, 16'hA5C3);
    @(posedge Clk); #1;
    chk("sync e3", bus.Data_to_CPU, 16'h5A3C);

    // Reset pulse in the middle of a hex write
    @(negedge Clk);
    drive(16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h1234);
    @(posedge Clk); #1;
    chk("mrst pre", hexw(), 16'h1234);
    #1;
    Reset = 1'b1;
    #1;
    chk("mrst hex", hexw(), 16'h0000);
    chk("mrst dout", bus.Data_to_CPU, 16'h0000);
    @(posedge Clk); #1;
    chk("mrst hold", hexw(), 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    idle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a, d;
      logic ce, oe, we, io;
      @(negedge Clk);
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'h0040;
        2: a = 16'h1000;
        default: a = 16'($urandom_range(0, 7));
      endcase
      ce = ($urandom_range(0, 4) == 0);
      oe = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      drive(a, ce, oe, we, d);
      bus.Mem_UB = 1'($urandom_range(0, 1));
      bus.Mem_LB = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) Switches = 16'($urandom);
      #1;
      io = (a == 16'hFFFF) && !ce;
      chk("rnd we_n", 16'(SRAM_WE_N), 16'(!(!ce && !we && !io)));
      chk("rnd oe_n", 16'(SRAM_OE_N), 16'(!(!ce && !oe && we && !io)));
      chk("rnd ce_n", 16'(SRAM_CE_N), 16'(ce || io));
      if (!ce && !we && !io) chk("rnd dq", SRAM_DQ, d);
      @(posedge Clk); #1;
      chk("rnd dout", bus.Data_to_CPU, m_dout);
      chk("rnd hex", hexw(), m_hex);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
